psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter DataWidth, default 16, operand width of the upstream PE matrix; each product is 2*DataWidth bits.
REQ-002 Parameter AccWidth, default 2*DataWidth+16, width of the accumulated partial sum.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-006 k_size  input  4  kernel size K, latched at start.
REQ-007 num_ch  input  8  input-channel count C, latched at start.
REQ-008 abort  input  1  synchronous job cancel.
REQ-009 Bus_P  input  [2*DataWidth-1:0] x [10:0][10:0]  signed product bus, indexed [column][row].
REQ-010 p_valid  input  1  Bus_P holds one channel's products this cycle.
REQ-011 p_ready  output  1  block accepts Bus_P this cycle.
REQ-012 psum  output  AccWidth  signed accumulated partial sum.
REQ-013 psum_valid  output  1  psum is valid and held.
REQ-014 psum_ready  input  1  downstream accepts psum.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on the cycle psum is accepted.

Function
REQ-017 States: IDLE, ACCUM, DRAIN, OUTPUT.
REQ-018 IDLE->ACCUM on start: latch Keff = clamp(k_size,1,11) and Ceff = max(num_ch,1); clear the accumulator and beat counter.
REQ-019 p_ready shall be 1 only in ACCUM while beat count < Ceff; a beat is accepted when p_valid && p_ready.
REQ-020 Window mask: product [c][r] contributes only when c<Keff and r<Keff; all others count as zero.
REQ-021 Pipeline stage 1 registers 11 sign-extended column sums; stage 2 registers their total; stage 3 adds that total into the accumulator. Each stage carries a valid bit.
REQ-022 Latency: an accepted beat reaches the accumulator exactly 3 cycles after acceptance; back-to-back beats shall be accepted every cycle.
REQ-023 All sums are signed two's complement at full AccWidth; no saturation, since 121*256 products cannot overflow AccWidth at default width.
REQ-024 ACCUM->DRAIN on the cycle the Ceff-th beat is accepted.
REQ-025 DRAIN->OUTPUT once all pipeline valid bits are clear and the last beat has been accumulated.
REQ-026 In OUTPUT, psum_valid=1 and psum stays stable until psum_ready=1.
REQ-027 On psum_valid && psum_ready: pulse done and return to IDLE.
REQ-028 start in any non-IDLE state is ignored.
REQ-029 abort in any state returns to IDLE on the next edge, clears the pipeline valid bits, accumulator and counter, and produces no done.
REQ-030 When abort and psum_ready coincide in OUTPUT, abort wins and done stays 0.
REQ-031 start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
REQ-032 p_valid while p_ready=0 is ignored and does not change state.

Reset
REQ-033 RST=1 asynchronously forces IDLE and sets p_ready=0, psum=0, psum_valid=0, busy=0, done=0, and clears every pipeline register, valid bit and latched configuration.
REQ-034 Reset mid-job discards the job; after RST falls, the block waits for a fresh start.

Structure
REQ-035 A shared package shall hold the state enum, the matrix dimension constant (11), the K-clamp limits, and the AccWidth default.
REQ-036 One sub-module, psum_col_adder, shall compute one masked column sum; it is instantiated 11 times.

Verification
REQ-037 K=3, C=1, all products = 1 -> p_ready drops after 1 beat; psum=9; psum_valid asserts 4 cycles after acceptance; done pulses when psum_ready=1.
REQ-038 K=11, C=4, product[c][r] = c+r, beats back-to-back -> no stalls; psum = 4*1210 = 4840.
REQ-039 K=0 and K=15 with all products = 2, C=1 -> psum=2 for K=0 and psum=242 for K=15.
REQ-040 K=5, C=2, all products = -32768*32767 -> psum = -50*1073709056, correct sign-extended value with no wrap.
REQ-041 Hold psum_ready=0 for 10 cycles in OUTPUT -> psum stays stable and psum_valid stays 1; a second start is ignored; done pulses once when psum_ready rises.
REQ-042 abort after 2 of C=5 beats, and separately RST pulsed mid-ACCUM -> IDLE, psum_valid=0, no done; the next job with K=1, C=1, product=7 gives psum=7.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
// Holds the FSM state encoding, the PE matrix dimension, the kernel-size
// clamp limits, the default data/accumulator widths and small helpers that
// derive the effective job configuration.
package psum_accumulator_pkg;

    localparam int unsigned MatDim       = 11;
    localparam int unsigned KMin         = 1;
    localparam int unsigned KMax         = 11;
    localparam int unsigned KWidth       = 4;
    localparam int unsigned CWidth       = 8;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAccWidth  = 2 * DefDataWidth + 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Effective kernel size: clamp(k, KMin, KMax).
    function automatic logic [KWidth-1:0] clamp_k(input logic [KWidth-1:0] k);
        if (k < KWidth'(KMin)) begin
            return KWidth'(KMin);
        end else if (k > KWidth'(KMax)) begin
            return KWidth'(KMax);
        end else begin
            return k;
        end
    endfunction

    // Effective channel count: a zero request still runs one beat.
    function automatic logic [CWidth-1:0] max_c(input logic [CWidth-1:0] c);
        return (c == '0) ? CWidth'(1) : c;
    endfunction

endpackage

// File: rtl/psum_col_adder.sv
// Masked column adder.
// Sums the MatDim products of one matrix column, sign-extended to AccWidth.
// Products contribute only when both the column index and the row index lie
// inside the effective KxK window; everything else counts as zero.
// Ports:
//   col   - the MatDim signed products of this column, indexed by row
//   keff  - effective kernel size (1..11)
//   sum_c - combinational masked column sum
module psum_col_adder
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AccWidth  = DefAccWidth,
    parameter int unsigned ColIdx    = 0
) (
    input  logic [MatDim-1:0][2*DataWidth-1:0] col,
    input  logic [KWidth-1:0]                  keff,
    output logic signed [AccWidth-1:0]         sum_c
);

    logic col_en_c;

    assign col_en_c = (KWidth'(ColIdx) < keff);

    // Sign-extend each in-window product before summing.
    always_comb begin
        sum_c = '0;
        for (int unsigned r = 0; r < MatDim; r++) begin
            if (col_en_c && (KWidth'(r) < keff)) begin
                sum_c = sum_c + AccWidth'($signed(col[r]));
            end
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for an 11x11 PE product matrix.
// A job is started in IDLE with a kernel size K and channel count C. Each
// accepted beat of Bus_P is masked to the KxK window, reduced through a
// three-stage pipeline (column sums, total, accumulate) and the final sum is
// presented on psum with a valid/ready handshake.
// Ports:
//   CLK, RST              - clock, asynchronous active-high reset
//   start, k_size, num_ch - job request and configuration (sampled in IDLE)
//   abort                 - synchronous job cancel, highest priority
//   Bus_P, p_valid/p_ready- product bus [column][row] and its handshake
//   psum, psum_valid/psum_ready - accumulated result and its handshake
//   busy                  - high whenever not IDLE
//   done                  - one-cycle pulse after the result is taken
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned AccWidth  = 2 * DataWidth + 16
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       start,
    input  logic [KWidth-1:0]                          k_size,
    input  logic [CWidth-1:0]                          num_ch,
    input  logic                                       abort,
    input  logic [MatDim-1:0][MatDim-1:0][2*DataWidth-1:0] Bus_P,
    input  logic                                       p_valid,
    output logic                                       p_ready,
    output logic signed [AccWidth-1:0]                 psum,
    output logic                                       psum_valid,
    input  logic                                       psum_ready,
    output logic                                       busy,
    output logic                                       done
);

    state_t                     state;
    logic [KWidth-1:0]          keff_q;
    logic [CWidth-1:0]          ceff_q;
    logic [CWidth-1:0]          beat_cnt;
    logic signed [AccWidth-1:0] acc;

    logic                       accept_c;
    logic signed [AccWidth-1:0] col_sum_c [MatDim];
    logic signed [AccWidth-1:0] s1_total_c;

    logic                       s1_valid;
    logic signed [AccWidth-1:0] s1_sum [MatDim];
    logic                       s2_valid;
    logic signed [AccWidth-1:0] s2_total;

    assign accept_c = p_valid && p_ready;

    // One masked adder per matrix column.
    for (genvar c = 0; c < MatDim; c++) begin : g_col
        psum_col_adder #(
            .DataWidth (DataWidth),
            .AccWidth  (AccWidth),
            .ColIdx    (c)
        ) u_col (
            .col   (Bus_P[c]),
            .keff  (keff_q),
            .sum_c (col_sum_c[c])
        );
    end

    // Total of the registered column sums feeding stage 2.
    always_comb begin
        s1_total_c = '0;
        for (int unsigned i = 0; i < MatDim; i++) begin
            s1_total_c = s1_total_c + s1_sum[i];
        end
    end

    // Stages 1 and 2: column sums, then their total, each with a valid bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_total <= '0;
            for (int unsigned i = 0; i < MatDim; i++) begin
                s1_sum[i] <= '0;
            end
        end else if (abort) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            s2_valid <= s1_valid;
            if (accept_c) begin
                for (int unsigned i = 0; i < MatDim; i++) begin
                    s1_sum[i] <= col_sum_c[i];
                end
            end
            if (s1_valid) begin
                s2_total <= s1_total_c;
            end
        end
    end

    // Control FSM with stage-3 accumulator and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            keff_q     <= '0;
            ceff_q     <= '0;
            beat_cnt   <= '0;
            acc        <= '0;
            p_ready    <= 1'b0;
            psum       <= '0;
            psum_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (s2_valid) begin
                acc <= acc + s2_total;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        keff_q   <= clamp_k(k_size);
                        ceff_q   <= max_c(num_ch);
                        beat_cnt <= '0;
                        acc      <= '0;
                        p_ready  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept_c) begin
                        beat_cnt <= beat_cnt + CWidth'(1);
                        if (beat_cnt + CWidth'(1) == ceff_q) begin
                            p_ready <= 1'b0;
                            state   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage 2 clear means the last beat is already in acc.
                    if (!s1_valid && !s2_valid) begin
                        psum       <= acc;
                        psum_valid <= 1'b1;
                        state      <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (psum_ready) begin
                        psum_valid <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Abort overrides every transition above, including the handshake.
            if (abort) begin
                state      <= ST_IDLE;
                beat_cnt   <= '0;
                acc        <= '0;
                p_ready    <= 1'b0;
                psum_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus
// randomized jobs compared against a window-sum reference model.
module tb_psum_accumulator;

    localparam int DW = 16;
    localparam int AW = 48;

    logic                          CLK = 1'b0;
    logic                          RST;
    logic                          start;
    logic [3:0]                    k_size;
    logic [7:0]                    num_ch;
    logic                          abort;
    logic [10:0][10:0][2*DW-1:0]   bus_p;
    logic                          p_valid;
    logic                          p_ready;
    logic signed [AW-1:0]          psum;
    logic                          psum_valid;
    logic                          psum_ready;
    logic                          busy;
    logic                          done;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_psum;
    int     lat;
    int     stalls;
    int     feed_cycles;
    logic   pr_after;
    logic   hs_done, hs_valid, hs_busy, hs_done2;

    always #5 CLK = ~CLK;

    psum_accumulator #(.DataWidth(DW), .AccWidth(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .k_size     (k_size),
        .num_ch     (num_ch),
        .abort      (abort),
        .Bus_P      (bus_p),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .psum       (psum),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference: sum of products inside the clamped KxK window.
    function automatic longint beat_model(input int k);
        int     keff;
        longint s;
        keff = (k < 1) ? 1 : ((k > 11) ? 11 : k);
        s = 0;
        for (int c = 0; c < 11; c++)
            for (int r = 0; r < 11; r++)
                if (c < keff && r < keff) s += longint'($signed(bus_p[c][r]));
        return s;
    endfunction

    // mode 0: constant, 1: c+r, 2: random
    task automatic fill(input int mode, input logic [31:0] val);
        for (int c = 0; c < 11; c++)
            for (int r = 0; r < 11; r++)
                case (mode)
                    0:       bus_p[c][r] = val;
                    1:       bus_p[c][r] = 32'(c + r);
                    default: bus_p[c][r] = $urandom;
                endcase
    endtask

    // Starts a job, feeds C beats, waits for psum_valid; records model result.
    task automatic run_job(input int k, input int c, input int mode,
                           input logic [31:0] val, input bit gaps, input bit junk);
        int ceff;
        int beats;
        int guard;
        start = 1'b1; k_size = 4'(k); num_ch = 8'(c);
        tick;
        start = 1'b0;
        ceff = (c == 0) ? 1 : c;
        exp_psum = 0; beats = 0; stalls = 0; feed_cycles = 0; guard = 0;
        while (beats < ceff && guard < 2000) begin
            fill(mode, val);
            p_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (p_valid && p_ready) begin
                exp_psum += beat_model(k);
                beats++;
            end else if (p_valid) begin
                stalls++;
            end
            feed_cycles++; guard++;
            tick;
        end
        p_valid = 1'b0;
        pr_after = p_ready;
        if (beats < ceff) begin
            n_cmp++; n_bad++;
            $display("FAIL job_feed: accepted %0d beats, required %0d", beats, ceff);
        end
        lat = 1;
        while (!psum_valid && lat < 40) begin
            if (junk) begin
                fill(2, 32'd0);
                p_valid = 1'b1;
            end
            tick;
            lat++;
        end
        p_valid = 1'b0;
        if (!psum_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL job_timeout: psum_valid=%0b after %0d cycles, required 1", psum_valid, lat);
        end
    endtask

    task automatic complete_hs;
        psum_ready = 1'b1;
        tick;
        psum_ready = 1'b0;
        hs_done = done; hs_valid = psum_valid; hs_busy = busy;
        tick;
        hs_done2 = done;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick; tick;
        n_cmp++;
        if ({p_ready, psum_valid, busy, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 0000", {p_ready, psum_valid, busy, done});
        end
        n_cmp++;
        if (psum !== '0) begin
            n_bad++; $display("FAIL reset_psum: got %0d required 0", psum);
        end
        RST = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        run_job(3, 1, 0, 32'd1, 1'b0, 1'b0);
        n_cmp++;
        if (pr_after !== 1'b0) begin n_bad++; $display("FAIL basic_pready_drop: got %b required 0", pr_after); end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL basic_latency: got %0d required 4", lat); end
        n_cmp++;
        if (psum !== 48'sd9) begin n_bad++; $display("FAIL basic_psum: got %0d required 9", psum); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b required 1", busy); end
        complete_hs;
        n_cmp++;
        if ({hs_done, hs_valid, hs_busy, hs_done2} !== 4'b1000) begin
            n_bad++;
            $display("FAIL basic_done: done,valid,busy,done_next got %b required 1000",
                     {hs_done, hs_valid, hs_busy, hs_done2});
        end
    endtask

    task automatic test_full_window;
        run_job(11, 4, 1, 32'd0, 1'b0, 1'b0);
        n_cmp++;
        if (stalls !== 0 || feed_cycles !== 4) begin
            n_bad++; $display("FAIL full_b2b: stalls %0d cycles %0d required 0 and 4", stalls, feed_cycles);
        end
        n_cmp++;
        if (psum !== 48'sd4840) begin n_bad++; $display("FAIL full_psum: got %0d required 4840", psum); end
        complete_hs;
        n_cmp++;
        if (hs_done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b required 1", hs_done); end
    endtask

    task automatic test_k_clamp;
        int     ks [2]  = '{0, 15};
        longint exp [2] = '{2, 242};
        for (int i = 0; i < 2; i++) begin
            run_job(ks[i], 1, 0, 32'd2, 1'b0, 1'b0);
            n_cmp++;
            if (longint'(psum) !== exp[i]) begin
                n_bad++; $display("FAIL kclamp_k%0d: got %0d required %0d", ks[i], psum, exp[i]);
            end
            complete_hs;
        end
    endtask

    task automatic test_neg_extreme;
        logic signed [31:0] pv;
        longint             exp;
        pv  = -32'sd1073709056;
        exp = -64'sd53685452800;
        run_job(5, 2, 0, pv, 1'b0, 1'b0);
        n_cmp++;
        if (longint'(psum) !== exp) begin
            n_bad++; $display("FAIL neg_psum: got %0d required %0d", psum, exp);
        end
        complete_hs;
    endtask

    task automatic test_hold_output;
        logic signed [AW-1:0] held;
        int                   dcount;
        run_job(4, 3, 2, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (longint'(psum) !== exp_psum) begin
            n_bad++; $display("FAIL hold_psum: got %0d required %0d", psum, exp_psum);
        end
        held = psum;
        for (int i = 0; i < 10; i++) begin
            psum_ready = 1'b0;
            if (i == 3) begin start = 1'b1; k_size = 4'd1; num_ch = 8'd1; end
            tick;
            start = 1'b0;
            n_cmp++;
            if (psum !== held || psum_valid !== 1'b1 || done !== 1'b0 || p_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: psum %0d valid %b done %b ready %b required %0d 1 0 0",
                         i, psum, psum_valid, done, p_ready, held);
            end
        end
        psum_ready = 1'b1;
        tick;
        psum_ready = 1'b0;
        dcount = int'(done);
        for (int i = 0; i < 4; i++) begin
            tick;
            dcount += int'(done);
        end
        n_cmp++;
        if (dcount !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL hold_done_once: pulses %0d busy %b required 1 and 0", dcount, busy);
        end
    endtask

    task automatic test_abort;
        int seen;
        start = 1'b1; k_size = 4'd2; num_ch = 8'd5;
        tick;
        start = 1'b0;
        fill(0, 32'd1);
        p_valid = 1'b1;
        tick; tick;
        p_valid = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++;
        if ({busy, p_ready, psum_valid} !== 3'b000) begin
            n_bad++; $display("FAIL abort_idle: busy,ready,valid got %b required 000", {busy, p_ready, psum_valid});
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen += int'(done) + int'(psum_valid);
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: events %0d required 0", seen); end
        run_job(1, 1, 0, 32'd7, 1'b0, 1'b0);
        n_cmp++;
        if (psum !== 48'sd7) begin n_bad++; $display("FAIL abort_next_psum: got %0d required 7", psum); end
        complete_hs;

        // abort and psum_ready together in OUTPUT
        run_job(2, 1, 0, 32'd3, 1'b0, 1'b0);
        abort = 1'b1; psum_ready = 1'b1;
        tick;
        abort = 1'b0; psum_ready = 1'b0;
        n_cmp++;
        if ({done, psum_valid, busy} !== 3'b000) begin
            n_bad++; $display("FAIL abort_vs_ready: done,valid,busy got %b required 000", {done, psum_valid, busy});
        end
        tick;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL abort_vs_ready_late: done %b required 0", done); end

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; k_size = 4'd3; num_ch = 8'd2;
        tick;
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if ({busy, p_ready} !== 2'b00) begin
            n_bad++; $display("FAIL start_abort_idle: busy,ready got %b required 00", {busy, p_ready});
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1; k_size = 4'd3; num_ch = 8'd3;
        tick;
        start = 1'b0;
        fill(0, 32'd5);
        p_valid = 1'b1;
        tick;
        p_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({busy, p_ready, psum_valid, done} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_async: busy,ready,valid,done got %b required 0000",
                              {busy, p_ready, psum_valid, done});
        end
        tick;
        RST = 1'b0;
        tick; tick;
        n_cmp++;
        if ({busy, p_ready, psum_valid, done} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_stay_idle: got %b required 0000", {busy, p_ready, psum_valid, done});
        end
        run_job(1, 1, 0, 32'd7, 1'b0, 1'b0);
        n_cmp++;
        if (psum !== 48'sd7) begin n_bad++; $display("FAIL rst_next_psum: got %0d required 7", psum); end
        complete_hs;
    endtask

    task automatic test_random;
        int k;
        int c;
        int hold;
        for (int j = 0; j < 8; j++) begin
            k = $urandom_range(0, 15);
            c = $urandom_range(0, 6);
            run_job(k, c, 2, 32'd0, 1'b1, 1'b1);
            n_cmp++;
            if (longint'(psum) !== exp_psum) begin
                n_bad++; $display("FAIL rand_job%0d_k%0d_c%0d: got %0d required %0d", j, k, c, psum, exp_psum);
            end
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) tick;
            complete_hs;
            n_cmp++;
            if (hs_done !== 1'b1 || hs_valid !== 1'b0) begin
                n_bad++; $display("FAIL rand_done%0d: done %b valid %b required 1 0", j, hs_done, hs_valid);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; start = 1'b0; k_size = '0; num_ch = '0; abort = 1'b0;
        p_valid = 1'b0; psum_ready = 1'b0;
        fill(0, 32'd0);
        test_reset;
        test_basic;
        test_full_window;
        test_k_clamp;
        test_neg_extreme;
        test_hold_output;
        test_abort;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
